// File: rtl/fb_pkg.sv
// Shared framebuffer constants and types for the arbiter and its write FIFO.
package fb_pkg;

    localparam int FB_ROW_W  = 7;
    localparam int FB_COL_W  = 7;
    localparam int FB_ADDR_W = 14;
    localparam int PIX_W     = 12;
    localparam int FB_WORDS  = 16384;

    // Arbiter sequencer: normal service, or full-frame clear sweep.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    // One queued tracer write.
    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [PIX_W-1:0]     data;
    } fb_wr_t;

    // Framebuffer word address is simply {row, col}; every value is legal.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FB_ROW_W-1:0] row,
                                                     input logic [FB_COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering tracer writes until a free RAM slot.
// Flags come from the registered count, so nothing here is combinational
// on push/pop.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   vga_clk,
    input  logic   clrn,
    input  logic   push,
    input  fb_wr_t push_ent,
    input  logic   pop,
    output fb_wr_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fb_wr_t           store [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Overflow/underflow can't corrupt state even if a caller misbehaves.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = store[rptr];

    // Pointers and occupancy; reset discards anything queued.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: it is only read when count says valid.
    always_ff @(posedge vga_clk) begin
        if (do_push) store[wptr] <= push_ent;
    end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads > clear sweep > buffered
// tracer writes. All RAM-side outputs are registered; read data returns a
// fixed two cycles after the request is sampled.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STALL_W    = 16
) (
    input  logic                 vga_clk,
    input  logic                 clrn,
    input  logic                 rd_req,
    input  logic [FB_ROW_W-1:0]  rd_row,
    input  logic [FB_COL_W-1:0]  rd_col,
    output logic [PIX_W-1:0]     rd_data,
    output logic                 rd_valid,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [FB_ROW_W-1:0]  wr_row,
    input  logic [FB_COL_W-1:0]  wr_col,
    input  logic [PIX_W-1:0]     wr_data,
    input  logic                 clr_req,
    input  logic [PIX_W-1:0]     clr_color,
    output logic                 clr_busy,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]     mem_wdata,
    input  logic [PIX_W-1:0]     mem_rdata,
    output logic [STALL_W-1:0]   stall_cnt
);

    // Read return path: issue edge, RAM edge, capture edge.
    localparam int RD_STAGES = 2;

    fb_state_t            state;
    logic [FB_ADDR_W-1:0] clr_addr;
    logic [PIX_W-1:0]     clr_fill;
    logic [RD_STAGES:0]   vld_pipe;

    fb_wr_t               fifo_in;
    fb_wr_t               fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 gnt_rd;
    logic                 gnt_clr;
    logic                 gnt_wr;

    // Slot grants: display never waits; queued writes only drain outside a
    // clear so tracer pixels always land on top of the fill colour.
    assign gnt_rd  = rd_req;
    assign gnt_clr = !rd_req && (state == CLEAR);
    assign gnt_wr  = !rd_req && (state == IDLE) && !fifo_empty;

    assign wr_ready = !fifo_full;
    assign push     = wr_valid && !fifo_full;
    assign clr_busy = (state == CLEAR);
    assign rd_valid = vld_pipe[RD_STAGES];

    assign fifo_in.addr = fb_addr(wr_row, wr_col);
    assign fifo_in.data = wr_data;

    fb_wr_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_wr_fifo (
        .vga_clk  (vga_clk),
        .clrn     (clrn),
        .push     (push),
        .push_ent (fifo_in),
        .pop      (gnt_wr),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Clear sequencer: address only advances on granted slots, so reads
    // that pre-empt the sweep never cause a skipped word.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            clr_addr <= '0;
            clr_fill <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        clr_fill <= clr_color;
                    end
                end
                CLEAR: begin
                    if (gnt_clr) begin
                        clr_addr <= clr_addr + 1'b1;
                        if (clr_addr == FB_ADDR_W'(FB_WORDS-1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered RAM port; address and write data hold when the slot is idle.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= gnt_rd || gnt_clr || gnt_wr;
            mem_we <= gnt_clr || gnt_wr;
            if (gnt_rd) begin
                mem_addr <= fb_addr(rd_row, rd_col);
            end else if (gnt_clr) begin
                mem_addr  <= clr_addr;
                mem_wdata <= clr_fill;
            end else if (gnt_wr) begin
                mem_addr  <= fifo_head.addr;
                mem_wdata <= fifo_head.data;
            end
        end
    end

    // Read-valid shift register; data is captured as the RAM output settles.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            vld_pipe <= '0;
            rd_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_STAGES-1:0], gnt_rd};
            if (vld_pipe[RD_STAGES-1]) rd_data <= mem_rdata;
        end
    end

    // Saturating count of cycles the tracer was held off by a full buffer.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= '0;
        end else if (wr_valid && fifo_full && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: behavioural RAM plus a transaction-level model
// (write queue, expected memory image, clear pointer) driven cycle by cycle.
module tb_fb_arbiter;

    localparam int DEPTH = 4;
    localparam int SW    = 4;
    localparam int SMAX  = 15;

    logic        vga_clk = 1'b0;
    logic        clrn = 1'b0;
    logic        rd_req = 1'b0;
    logic [6:0]  rd_row = '0, rd_col = '0;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [6:0]  wr_row = '0, wr_col = '0;
    logic [11:0] wr_data = '0;
    logic        clr_req = 1'b0;
    logic [11:0] clr_color = '0;
    logic        clr_busy;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [SW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    fb_arbiter #(.FIFO_DEPTH(DEPTH), .STALL_W(SW)) dut (
        .vga_clk(vga_clk), .clrn(clrn),
        .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [11:0] pat(input int a);
        if (a == 389) return 12'hABC;
        return 12'(a * 37 + 5);
    endfunction

    // Pixel RAM: one-cycle registered read, write commits at the edge.
    logic [11:0] ram [16384];
    logic        ram_init = 1'b0;
    always @(posedge vga_clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16384; i++) ram[i] <= pat(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model state.
    logic [25:0] mq[$];
    logic [11:0] m_mem [16384];
    logic        m_clr;
    int          m_ptr;
    logic [11:0] m_col;
    logic        exp_en, exp_we, exp_rv;
    logic [13:0] exp_addr;
    logic [11:0] exp_wdata, exp_rd;
    logic        pv1, pv2;
    logic [11:0] pd1, pd2;
    int          exp_stall;

    task automatic model_reset();
        mq.delete();
        m_clr = 0; m_ptr = 0; m_col = '0;
        exp_en = 0; exp_we = 0; exp_rv = 0;
        exp_addr = '0; exp_wdata = '0; exp_rd = '0;
        pv1 = 0; pv2 = 0; pd1 = '0; pd2 = '0;
        exp_stall = 0;
    endtask

    // Apply the current inputs to the model, then advance one clock.
    task automatic tick();
        int          sz;
        logic        rdy;
        logic        clr_was;
        logic [25:0] ent;
        sz      = mq.size();
        rdy     = (sz < DEPTH);
        clr_was = m_clr;
        exp_rv  = pv2;
        if (pv2) exp_rd = pd2;
        pv2 = pv1; pd2 = pd1; pv1 = 1'b0;
        if (rd_req) begin
            exp_en = 1; exp_we = 0; exp_addr = {rd_row, rd_col};
            pv1 = 1; pd1 = m_mem[exp_addr];
        end else if (m_clr) begin
            exp_en = 1; exp_we = 1; exp_addr = 14'(m_ptr); exp_wdata = m_col;
            m_mem[m_ptr] = m_col;
            m_ptr++;
            if (m_ptr == 16384) m_clr = 0;
        end else if (sz > 0) begin
            ent = mq.pop_front();
            exp_en = 1; exp_we = 1; exp_addr = ent[25:12]; exp_wdata = ent[11:0];
            m_mem[exp_addr] = exp_wdata;
        end else begin
            exp_en = 0; exp_we = 0;
        end
        if (wr_valid && rdy) mq.push_back({wr_row, wr_col, wr_data});
        if (wr_valid && !rdy && exp_stall < SMAX) exp_stall++;
        if (!clr_was && clr_req) begin
            m_clr = 1; m_ptr = 0; m_col = clr_color;
        end
        @(posedge vga_clk); #1;
    endtask

    task automatic do_reset(input bit init_ram);
        clrn = 0; rd_req = 0; wr_valid = 0; clr_req = 0; ram_init = init_ram;
        repeat (2) @(posedge vga_clk);
        #1;
        ram_init = 0;
        if (init_ram) for (int i = 0; i < 16384; i++) m_mem[i] = pat(i);
        model_reset();
        clrn = 1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (rd_data !== 0 || rd_valid !== 0 || clr_busy !== 0 || mem_we !== 0 ||
            mem_addr !== 0 || mem_wdata !== 0 || stall_cnt !== 0) begin
            n_err++;
            $display("FAIL reset_vals: rd_data=%h rd_valid=%b busy=%b we=%b addr=%h wdata=%h stall=%0d, want all 0",
                     rd_data, rd_valid, clr_busy, mem_we, mem_addr, mem_wdata, stall_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (mem_en !== 1'b0 || wr_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: mem_en=%b wr_ready=%b, want 0/1", i, mem_en, wr_ready);
            end
        end
    endtask

    task automatic test_read_latency();
        rd_req = 1; rd_row = 7'd3; rd_col = 7'd5;
        tick();
        rd_req = 0;
        n_cmp++;
        if (mem_en !== 1 || mem_we !== 0 || mem_addr !== 14'd389) begin
            n_err++;
            $display("FAIL rd_issue: en=%b we=%b addr=%0d, want 1/0/389", mem_en, mem_we, mem_addr);
        end
        tick();
        n_cmp++;
        if (rd_valid !== 0) begin
            n_err++;
            $display("FAIL rd_early: rd_valid=%b, want 0", rd_valid);
        end
        tick();
        n_cmp++;
        if (rd_valid !== 1 || rd_data !== 12'hABC) begin
            n_err++;
            $display("FAIL rd_data: valid=%b data=%h, want 1/abc", rd_valid, rd_data);
        end
    endtask

    task automatic test_write_drain();
        logic [11:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = 12'($urandom);
        for (int t = 0; t < 5; t++) begin
            wr_valid = (t < 3); wr_row = 0; wr_col = 7'(10 + t); wr_data = (t < 3) ? d[t] : 12'h0;
            tick();
            n_cmp++;
            if (t == 0 || t == 4) begin
                if (mem_en !== 0) begin
                    n_err++;
                    $display("FAIL drain_gap[%0d]: mem_en=%b, want 0", t, mem_en);
                end
            end else if (mem_en !== 1 || mem_we !== 1 || mem_addr !== 14'(9 + t) || mem_wdata !== d[t-1]) begin
                n_err++;
                $display("FAIL drain_wr[%0d]: en=%b we=%b addr=%0d data=%h, want 1/1/%0d/%h",
                         t, mem_en, mem_we, mem_addr, mem_wdata, 9 + t, d[t-1]);
            end
        end
        wr_valid = 0;
        for (int t = 0; t < 5; t++) begin
            rd_req = (t < 3); rd_row = 0; rd_col = 7'(10 + t);
            tick();
            if (t >= 2) begin
                n_cmp++;
                if (rd_valid !== 1 || rd_data !== d[t-2]) begin
                    n_err++;
                    $display("FAIL drain_rb[%0d]: valid=%b data=%h, want 1/%h", t - 2, rd_valid, rd_data, d[t-2]);
                end
            end
        end
        rd_req = 0;
    endtask

    task automatic test_read_priority();
        logic [11:0] wd [6];
        int          s0;
        int          sx;
        s0 = exp_stall;
        for (int i = 0; i < 6; i++) wd[i] = 12'($urandom);
        for (int t = 0; t < 10; t++) begin
            n_cmp++;
            if (wr_ready !== (t < 4)) begin
                n_err++;
                $display("FAIL prio_ready[%0d]: wr_ready=%b, want %0d", t, wr_ready, (t < 4));
            end
            rd_req = 1; rd_row = 7'($urandom); rd_col = 7'($urandom);
            wr_valid = (t < 6); wr_row = 0; wr_col = 7'(20 + t); wr_data = (t < 6) ? wd[t] : 12'h0;
            tick();
            n_cmp++;
            if (mem_we !== 0 || mem_en !== 1) begin
                n_err++;
                $display("FAIL prio_we[%0d]: en=%b we=%b, want 1/0", t, mem_en, mem_we);
            end
        end
        wr_valid = 0; rd_req = 0;
        sx = (s0 + 2 > SMAX) ? SMAX : s0 + 2;
        n_cmp++;
        if (stall_cnt !== 4'(sx)) begin
            n_err++;
            $display("FAIL prio_stall: stall_cnt=%0d, want %0d", stall_cnt, sx);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (i == 4) begin
                if (mem_en !== 0) begin
                    n_err++;
                    $display("FAIL prio_done: mem_en=%b, want 0", mem_en);
                end
            end else if (mem_en !== 1 || mem_we !== 1 || mem_addr !== 14'(20 + i) || mem_wdata !== wd[i]) begin
                n_err++;
                $display("FAIL prio_drain[%0d]: en=%b we=%b addr=%0d data=%h, want 1/1/%0d/%h",
                         i, mem_en, mem_we, mem_addr, mem_wdata, 20 + i, wd[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            n_cmp++;
            if (wr_ready !== (mq.size() < DEPTH)) begin
                n_err++;
                $display("FAIL rnd_ready[%0d]: wr_ready=%b, want %0d", c, wr_ready, (mq.size() < DEPTH));
            end
            rd_req   = ($urandom_range(0, 99) < 45);
            rd_row   = 0; rd_col = 7'($urandom_range(0, 15));
            wr_valid = (c < 580) && ($urandom_range(0, 99) < 60);
            wr_row   = 0; wr_col = 7'($urandom_range(0, 15)); wr_data = 12'($urandom);
            tick();
            n_cmp++;
            if (mem_en !== exp_en || (exp_en && (mem_we !== exp_we || mem_addr !== exp_addr)) ||
                (exp_en && exp_we && mem_wdata !== exp_wdata)) begin
                n_err++;
                $display("FAIL rnd_bus[%0d]: en=%b we=%b addr=%0d data=%h, want %b/%b/%0d/%h",
                         c, mem_en, mem_we, mem_addr, mem_wdata, exp_en, exp_we, exp_addr, exp_wdata);
            end
            n_cmp++;
            if (rd_valid !== exp_rv || (exp_rv && rd_data !== exp_rd)) begin
                n_err++;
                $display("FAIL rnd_rd[%0d]: valid=%b data=%h, want %b/%h", c, rd_valid, rd_data, exp_rv, exp_rd);
            end
            n_cmp++;
            if (stall_cnt !== 4'(exp_stall)) begin
                n_err++;
                $display("FAIL rnd_stall[%0d]: stall_cnt=%0d, want %0d", c, stall_cnt, exp_stall);
            end
        end
        rd_req = 0; wr_valid = 0;
        repeat (6) tick();
    endtask

    task automatic test_clear();
        int n;
        clr_color = 12'h0F0; clr_req = 1;
        tick();
        clr_req = 0; clr_color = 0;
        n = 0;
        while (clr_busy === 1'b1 && n < 20000) begin
            n++;
            wr_valid = (n == 100); wr_row = 0; wr_col = 0; wr_data = 12'h123;
            clr_req = (n == 5000); clr_color = (n == 5000) ? 12'hFFF : 12'h000;
            tick();
            n_cmp++;
            if (mem_en !== exp_en || mem_we !== exp_we || (exp_en && mem_addr !== exp_addr)) begin
                n_err++;
                $display("FAIL clr_bus[%0d]: en=%b we=%b addr=%0d, want %b/%b/%0d",
                         n, mem_en, mem_we, mem_addr, exp_en, exp_we, exp_addr);
            end
        end
        wr_valid = 0; clr_req = 0; clr_color = 0;
        n_cmp++;
        if (n !== 16384) begin
            n_err++;
            $display("FAIL clr_len: busy for %0d cycles, want 16384", n);
        end
        tick();
        n_cmp++;
        if (mem_en !== 1 || mem_we !== 1 || mem_addr !== 14'd0 || mem_wdata !== 12'h123) begin
            n_err++;
            $display("FAIL clr_then_wr: en=%b we=%b addr=%0d data=%h, want 1/1/0/123",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        for (int a = 0; a < 16386; a++) begin
            rd_req = (a < 16384); rd_row = a[13:7]; rd_col = a[6:0];
            tick();
            if (a >= 2) begin
                n_cmp++;
                if (rd_valid !== 1 || rd_data !== ((a == 2) ? 12'h123 : 12'h0F0)) begin
                    n_err++;
                    $display("FAIL clr_rb[%0d]: valid=%b data=%h, want 1/%h",
                             a - 2, rd_valid, rd_data, (a == 2) ? 12'h123 : 12'h0F0);
                end
            end
        end
        rd_req = 0;
    endtask

    task automatic test_reset_abort();
        clr_color = 12'h555; clr_req = 1;
        tick();
        clr_req = 0;
        for (int i = 0; i < 40; i++) begin
            wr_valid = (i < 2); wr_row = 1; wr_col = 7'(i); wr_data = 12'h777;
            tick();
        end
        wr_valid = 0;
        #2 clrn = 0;
        #1;
        n_cmp++;
        if (clr_busy !== 0 || mem_en !== 0 || wr_ready !== 1 || rd_valid !== 0 || stall_cnt !== 0) begin
            n_err++;
            $display("FAIL abort_rst: busy=%b en=%b ready=%b valid=%b stall=%0d, want 0/0/1/0/0",
                     clr_busy, mem_en, wr_ready, rd_valid, stall_cnt);
        end
        @(posedge vga_clk); #1;
        clrn = 1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (mem_en !== 0 || clr_busy !== 0) begin
                n_err++;
                $display("FAIL abort_idle[%0d]: en=%b busy=%b, want 0/0", i, mem_en, clr_busy);
            end
        end
    endtask

    initial begin
        do_reset(1'b1);
        test_reset();
        test_read_latency();
        test_write_drain();
        test_read_priority();
        test_random();
        test_clear();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
